// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared constants, state type and CRC7 step for the SD CMD responder
package sd_pkg;

  localparam logic [6:0] CRC7_POLY   = 7'h09;
  localparam logic [7:0] FRAME_SHORT = 8'd48;
  localparam logic [7:0] FRAME_LONG  = 8'd136;
  localparam logic [5:0] R2_INDEX    = 6'h3F;

  // Bits of each TX frame that precede the CRC field (start..payload end).
  localparam logic [7:0] DATA_SHORT  = 8'd40;
  localparam logic [7:0] DATA_LONG   = 8'd128;
  // First CRC-covered bit of a long frame: the 8-bit R2 header is excluded.
  localparam logic [7:0] CRC_START_LONG = 8'd8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX,
    ST_CHECK,
    ST_WAIT,
    ST_TX,
    ST_RELEASE
  } sd_state_e;

  // One serial CRC7 step, MSB-first.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// rtl/sd_crc7.sv - serial CRC7 generator/checker shared by the RX and TX paths
import sd_pkg::*;

module sd_crc7 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_i,
  output logic [6:0] crc_o
);

  logic [6:0] crc_q;
  logic [6:0] crc_d;
  logic [6:0] base;

  // Clear seeds zero and may be combined with en so the first bit is absorbed on the same edge.
  always_comb begin
    base  = clr ? 7'h00 : crc_q;
    crc_d = en ? crc7_step(base, bit_i) : base;
  end

  // Remainder register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= 7'h00;
    else        crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/sd_cmd_responder.sv
// rtl/sd_cmd_responder.sv - card-side SD CMD line: command receive/check and response transmit
import sd_pkg::*;

module sd_cmd_responder #(
  parameter int NCR           = 2,
  parameter int RSP_TIMEOUT_W = 8,
  parameter int RSP_TIMEOUT   = 200
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sd_cmd_i,
  output logic         sd_cmd_o,
  output logic         sd_cmd_oe,
  output logic         cmd_valid,
  output logic [5:0]   cmd_index,
  output logic [31:0]  cmd_arg,
  output logic         cmd_err,
  input  logic         rsp_valid,
  input  logic         rsp_none,
  input  logic         rsp_long,
  input  logic [119:0] rsp_data,
  output logic         rsp_ready,
  output logic         rsp_timeout
);

  localparam logic [6:0]               NCR_LAST = 7'(NCR - 1);
  localparam logic [RSP_TIMEOUT_W-1:0] WD_LAST  = RSP_TIMEOUT_W'(RSP_TIMEOUT - 1);
  localparam logic [RSP_TIMEOUT_W-1:0] WD_ONE   = RSP_TIMEOUT_W'(1);

  sd_state_e              state_q, state_d;
  logic [7:0]             bit_cnt_q, bit_cnt_d;
  logic [45:0]            rx_shift_q, rx_shift_d;
  logic [135:0]           tx_shift_q, tx_shift_d;
  logic                   tx_long_q, tx_long_d;
  logic [6:0]             ncr_cnt_q, ncr_cnt_d;
  logic [RSP_TIMEOUT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic                   sd_cmd_o_q, sd_cmd_o_d;
  logic                   sd_cmd_oe_q, sd_cmd_oe_d;
  logic                   cmd_valid_q, cmd_valid_d;
  logic                   cmd_err_q, cmd_err_d;
  logic                   rsp_timeout_q, rsp_timeout_d;
  logic [5:0]             cmd_index_q, cmd_index_d;
  logic [31:0]            cmd_arg_q, cmd_arg_d;

  logic       crc_clr, crc_en, crc_bit;
  logic [6:0] crc;
  logic [135:0] frame;
  logic [7:0] next_bit, last_bit, data_len, crc_start;
  logic       frame_good;

  sd_crc7 u_crc7 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (crc_clr),
    .en    (crc_en),
    .bit_i (crc_bit),
    .crc_o (crc)
  );

  assign rsp_ready = (state_q == ST_WAIT) && (ncr_cnt_q >= NCR_LAST);

  // Next-state, datapath and output decode for the whole command/response cycle.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    tx_long_d     = tx_long_q;
    ncr_cnt_d     = ncr_cnt_q;
    wd_cnt_d      = wd_cnt_q;
    sd_cmd_o_d    = sd_cmd_o_q;
    sd_cmd_oe_d   = sd_cmd_oe_q;
    cmd_valid_d   = 1'b0;
    cmd_err_d     = 1'b0;
    rsp_timeout_d = 1'b0;
    cmd_index_d   = cmd_index_q;
    cmd_arg_d     = cmd_arg_q;
    crc_clr       = 1'b0;
    crc_en        = 1'b0;
    crc_bit       = sd_cmd_i;
    frame         = '0;
    next_bit      = bit_cnt_q + 8'd1;
    last_bit      = tx_long_q ? FRAME_LONG - 8'd1 : FRAME_SHORT - 8'd1;
    data_len      = tx_long_q ? DATA_LONG : DATA_SHORT;
    crc_start     = tx_long_q ? CRC_START_LONG : 8'd0;
    frame_good    = rx_shift_q[45] && (rx_shift_q[6:0] == crc) && sd_cmd_i;

    case (state_q)
      ST_IDLE: begin
        if (!sd_cmd_i) begin
          state_d   = ST_RX;
          bit_cnt_d = 8'd1;
          crc_clr   = 1'b1;
          crc_en    = 1'b1;
        end
      end

      ST_RX: begin
        if (bit_cnt_q == FRAME_SHORT - 8'd1) begin
          // End bit on this edge: verdict is registered so the pulse lands in the CHECK cycle.
          state_d   = ST_CHECK;
          ncr_cnt_d = 7'd0;
          if (frame_good) begin
            cmd_valid_d = 1'b1;
            cmd_index_d = rx_shift_q[44:39];
            cmd_arg_d   = rx_shift_q[38:7];
          end else begin
            cmd_err_d = 1'b1;
          end
        end else begin
          rx_shift_d = {rx_shift_q[44:0], sd_cmd_i};
          bit_cnt_d  = next_bit;
          crc_en     = (bit_cnt_q <= 8'd39);
        end
      end

      ST_CHECK: begin
        state_d   = cmd_valid_q ? ST_WAIT : ST_IDLE;
        ncr_cnt_d = (ncr_cnt_q < NCR_LAST) ? ncr_cnt_q + 7'd1 : ncr_cnt_q;
        wd_cnt_d  = '0;
      end

      ST_WAIT: begin
        if (ncr_cnt_q < NCR_LAST) ncr_cnt_d = ncr_cnt_q + 7'd1;
        if (wd_cnt_q != WD_LAST)  wd_cnt_d  = wd_cnt_q + WD_ONE;
        if (rsp_none) begin
          state_d = ST_IDLE;
        end else if (rsp_valid && rsp_ready) begin
          frame       = rsp_long ? {2'b00, R2_INDEX, rsp_data, 8'h00}
                                 : {2'b00, rsp_data[37:0], 96'h0};
          state_d     = ST_TX;
          tx_long_d   = rsp_long;
          tx_shift_d  = {frame[134:0], 1'b0};
          bit_cnt_d   = 8'd0;
          sd_cmd_o_d  = frame[135];
          sd_cmd_oe_d = 1'b1;
          crc_clr     = 1'b1;
          crc_en      = !rsp_long;
          crc_bit     = frame[135];
        end else if (!sd_cmd_i) begin
          state_d   = ST_RX;
          bit_cnt_d = 8'd1;
          crc_clr   = 1'b1;
          crc_en    = 1'b1;
        end else if (wd_cnt_q == WD_LAST) begin
          state_d       = ST_IDLE;
          rsp_timeout_d = 1'b1;
        end
      end

      ST_TX: begin
        if (bit_cnt_q == last_bit) begin
          state_d    = ST_RELEASE;
          sd_cmd_o_d = 1'b1;
        end else begin
          bit_cnt_d = next_bit;
          if (next_bit < data_len) begin
            sd_cmd_o_d = tx_shift_q[135];
            tx_shift_d = {tx_shift_q[134:0], 1'b0};
            crc_en     = (next_bit >= crc_start);
            crc_bit    = tx_shift_q[135];
          end else if (next_bit < last_bit) begin
            // Feeding the remainder MSB back in shifts the CRC out unchanged.
            sd_cmd_o_d = crc[6];
            crc_en     = 1'b1;
            crc_bit    = crc[6];
          end else begin
            sd_cmd_o_d = 1'b1;
          end
        end
      end

      ST_RELEASE: begin
        state_d     = ST_IDLE;
        sd_cmd_o_d  = 1'b1;
        sd_cmd_oe_d = 1'b0;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset releases the line immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= 8'd0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      tx_long_q     <= 1'b0;
      ncr_cnt_q     <= 7'd0;
      wd_cnt_q      <= '0;
      sd_cmd_o_q    <= 1'b1;
      sd_cmd_oe_q   <= 1'b0;
      cmd_valid_q   <= 1'b0;
      cmd_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      cmd_index_q   <= 6'd0;
      cmd_arg_q     <= 32'd0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      tx_long_q     <= tx_long_d;
      ncr_cnt_q     <= ncr_cnt_d;
      wd_cnt_q      <= wd_cnt_d;
      sd_cmd_o_q    <= sd_cmd_o_d;
      sd_cmd_oe_q   <= sd_cmd_oe_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_err_q     <= cmd_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      cmd_index_q   <= cmd_index_d;
      cmd_arg_q     <= cmd_arg_d;
    end
  end

  assign sd_cmd_o    = sd_cmd_o_q;
  assign sd_cmd_oe   = sd_cmd_oe_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_err     = cmd_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign cmd_index   = cmd_index_q;
  assign cmd_arg     = cmd_arg_q;

endmodule

// File: doc/sd_cmd_responder.md
Name: sd_cmd_responder

Overview:
Card-side (responder) end of the SD CMD line. It receives 48-bit host command frames, checks the framing and CRC7, and hands the command index and argument to card logic. It then serialises the short (48-bit) or long (136-bit, R2) response frame that the card logic supplies. It is used as the SD-card model/emulator counterpart of the controller's command path, and its response formats match the controller's 120-bit response register.

Parameters:
NCR, 2, minimum clocks from command end-bit sample to response start bit (legal 2..64)
RSP_TIMEOUT_W, 8, width of the WAIT-state watchdog counter
RSP_TIMEOUT, 200, cycles in WAIT without rsp_valid/rsp_none before abandoning the command

Ports:
clk  in  1  SD clock; the CMD line is sampled and driven on the rising edge
rst_n  in  1  asynchronous, active-low reset
sd_cmd_i  in  1  CMD line input
sd_cmd_o  out  1  CMD line drive value
sd_cmd_oe  out  1  CMD line drive enable (pad tristates when 0)
cmd_valid  out  1  one-cycle pulse: a good command was received
cmd_index  out  6  command index, held until the next good command
cmd_arg  out  32  command argument, held until the next good command
cmd_err  out  1  one-cycle pulse: a CRC, transmission-bit or end-bit error was detected
rsp_valid  in  1  card logic offers a response
rsp_none  in  1  card logic declines to respond (takes priority over rsp_valid)
rsp_long  in  1  1 = R2 136-bit frame, 0 = 48-bit frame
rsp_data  in  120  long: payload bits [127:8]; short: [37:32] = index, [31:0] = payload
rsp_ready  out  1  high in WAIT once the NCR count has elapsed; accept = rsp_valid & rsp_ready
rsp_timeout  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset values: sd_cmd_o=1, sd_cmd_oe=0, cmd_valid=0, cmd_err=0, rsp_ready=0, rsp_timeout=0, cmd_index=0, cmd_arg=0, state=IDLE. Reset clears all of these immediately (asynchronously), including in mid-transmission.
- States:
  - IDLE: on sd_cmd_i=0 (start bit) go to RX; the CRC7 is seeded with 0 and includes the start bit.
  - RX: shift 47 further bits MSB-first. The CRC covers bits 47..8.
  - CHECK (1 cycle, entered after the end-bit edge E):
    - Good frame requires transmission bit = 1, received CRC7 = computed CRC7, and end bit = 1.
    - Good frame: cmd_valid pulses in the cycle after E (latency 1), cmd_index/cmd_arg update, go to WAIT.
    - Bad frame: cmd_err pulses in the cycle after E, go to IDLE; no response is sent.
  - WAIT:
    - Counts cycles from E; rsp_ready asserts once the count reaches NCR-1.
    - rsp_none (any cycle) -> IDLE.
    - Accept -> TX; sd_cmd_oe rises on the next edge, at the earliest E+NCR.
    - A start bit seen on sd_cmd_i -> RX (host retried); any pending response is discarded.
    - Watchdog reaches RSP_TIMEOUT -> rsp_timeout pulse, go to IDLE.
  - TX:
    - Short frame, 48 bits: 0, 0, rsp_data[37:32], rsp_data[31:0], CRC7 over the first 40 bits, 1.
    - Long frame, 136 bits: 0, 0, 6'b111111, rsp_data[119:0], CRC7 over the 120 payload bits only, 1.
    - The frame is latched on accept; later rsp_data changes are ignored.
  - RELEASE: one cycle driving oe=1, o=1 after the end bit, then oe=0 and go to IDLE.
- sd_cmd_i is ignored while sd_cmd_oe=1.
- Counters:
  - Bit counter is 8 bits (max 136).
  - NCR and watchdog counters saturate; there is no wrap-around.
- Simultaneous events:
  - rsp_none with rsp_valid: none wins.
  - Start bit in the same cycle as accept: accept wins.

Decomposition:
- Shared package sd_pkg:
  - CRC7 polynomial 7'h09 (x^7+x^3+1)
  - frame lengths (48, 136)
  - R2 index constant 6'h3F
  - state enumeration
- Sub-module sd_crc7: serial CRC7 with clear, enable and bit in; 7-bit remainder out. One instance serves both RX and TX, since they are never active together.

Test Plan:
- CMD0 bytes 40 00 00 00 00 95 sent MSB-first -> cmd_valid one cycle after the end bit, index=0, arg=0; rsp_none -> oe never asserts, state returns to IDLE.
- CMD8 frame 48 00 00 01 AA 87, short response with index=8 and payload 0x000001AA given immediately -> oe rises exactly NCR=2 cycles after the end bit; line carries 08 00 00 01 AA 13, then one drive-high cycle, then oe=0.
- CMD8 with the last CRC byte corrupted to 86 -> cmd_err pulse, no cmd_valid, oe stays 0.
- R2: rsp_long=1, rsp_data=120'h1 -> 136 bits driven; bits 133:128 = 6'b111111; CRC matches an independent model; end bit = 1.
- No response from card logic -> rsp_timeout after 200 cycles in WAIT. New CMD55 (77 00 00 00 00 65) sent during WAIT -> cmd_valid with index=55.
- rst_n pulled low at bit 20 of TX -> oe=0 and o=1 immediately (asynchronous); after release, a CMD0 is received normally.
